reg_bank_sb: RTL and testbench

- 32 x XLEN integer register bank for the RV32 core, with two combinational read ports and one synchronous write port.
- Includes a per-register busy scoreboard for long-latency producers (loads, multi-cycle ALU ops).
- Sits directly upstream of the read-port selection; each read port's output feeds the decode/operand-fetch stage.
- Decode issues an instruction only when no stall is flagged, closing the RAW/WAW hazard loop.

---
 rtl/reg_bank_sb_pkg.sv | 14 +
 rtl/reg_bank_sb_if.sv | 39 +++
 rtl/mux_32to1.sv | 13 +
 rtl/reg_bank_sb_scoreboard.sv | 66 ++++++
 rtl/reg_bank_sb.sv | 81 ++++++++
 tb/tb_reg_bank_sb.sv | 351 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/reg_bank_sb_pkg.sv
// Shared RV32 register-file types and constants.
// Imported by the bank, its interface, scoreboard and read muxes.
package riscv_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xword_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/reg_bank_sb_if.sv
// Register bank bus: two read ports, writeback, issue and scoreboard status.
// master = decode/writeback side, slave = register bank.
interface reg_bank_sb_if;
  import riscv_pkg::*;

  reg_idx_t rs1_addr;
  reg_idx_t rs2_addr;
  logic     rs1_used;
  logic     rs2_used;
  xword_t   rs1_data;
  xword_t   rs2_data;

  logic     wr_en;
  reg_idx_t wr_addr;
  xword_t   wr_data;
  logic     wr_clr_busy;

  logic     issue_en;
  reg_idx_t issue_rd;
  logic     issue_long;

  logic                stall;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output rs1_addr, rs2_addr, rs1_used, rs2_used,
    output wr_en, wr_addr, wr_data, wr_clr_busy,
    output issue_en, issue_rd, issue_long,
    input  rs1_data, rs2_data, stall, busy_vec
  );

  modport slave (
    input  rs1_addr, rs2_addr, rs1_used, rs2_used,
    input  wr_en, wr_addr, wr_data, wr_clr_busy,
    input  issue_en, issue_rd, issue_long,
    output rs1_data, rs2_data, stall, busy_vec
  );

endinterface

// File: rtl/mux_32to1.sv
// 32-way word selector used for each register read port.
// Ports: din (32 packed words), sel (index), dout (selected word).
module mux_32to1 #(
  parameter int W = 32
) (
  input  logic [31:0][W-1:0] din,
  input  logic [4:0]         sel,
  output logic [W-1:0]       dout
);

  assign dout = din[sel];

endmodule

// File: rtl/reg_bank_sb_scoreboard.sv
// Per-register busy scoreboard and RAW/WAW stall generation.
// Ports: read/issue/writeback qualifiers in, stall and busy_vec out.
// REG_BYPASS_EN: busy bits being cleared this cycle are masked from stall.
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  reg_idx_t            rs1_addr,
  input  reg_idx_t            rs2_addr,
  input  logic                rs1_used,
  input  logic                rs2_used,
  input  logic                wr_en,
  input  reg_idx_t            wr_addr,
  input  logic                wr_clr_busy,
  input  logic                issue_en,
  input  reg_idx_t            issue_rd,
  input  logic                issue_long,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam logic [NUM_REGS-1:0] X0_MASK =
    {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_eff;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic                fire;

  always_comb begin
    clr_mask = '0;
    if (wr_en && wr_clr_busy)
      clr_mask[wr_addr] = 1'b1;
  end

`ifdef REG_BYPASS_EN
  assign busy_eff = busy_q & ~clr_mask;
`else
  assign busy_eff = busy_q;
`endif

  assign stall = (rs1_used && busy_eff[rs1_addr])
               | (rs2_used && busy_eff[rs2_addr])
               | (issue_en && busy_eff[issue_rd]);

  assign fire = issue_en && !stall;

  always_comb begin
    set_mask = '0;
    if (fire && issue_long && issue_rd != ZERO_REG)
      set_mask[issue_rd] = 1'b1;
  end

  // Set applied after clear: a new producer outranks the old one.
  always_ff @(posedge clk) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= ((busy_q & ~clr_mask) | set_mask) & X0_MASK;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_bank_sb.sv
// 32 x XLEN register bank with 2 read ports, 1 write port, busy scoreboard.
// Ports: clk, rst (sync, active high), bus (reg_bank_sb_if.slave).
// REG_BYPASS_EN: same-cycle write-to-read forwarding and stall release.
module reg_bank_sb
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  reg_bank_sb_if.slave bus
);

  xword_t regs_q [NUM_REGS];

  logic [NUM_REGS-1:0][XLEN-1:0] rf;
  xword_t rd1;
  xword_t rd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (bus.wr_en && bus.wr_addr != ZERO_REG) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // x0 is tied off here so the muxes never see stored state for it.
  always_comb begin
    rf[0] = '0;
    for (int i = 1; i < NUM_REGS; i++)
      rf[i] = regs_q[i];
  end

  mux_32to1 #(.W(XLEN)) u_mux1 (
    .din  (rf),
    .sel  (bus.rs1_addr),
    .dout (rd1)
  );

  mux_32to1 #(.W(XLEN)) u_mux2 (
    .din  (rf),
    .sel  (bus.rs2_addr),
    .dout (rd2)
  );

`ifdef REG_BYPASS_EN
  logic fwd1;
  logic fwd2;

  assign fwd1 = bus.wr_en
             && bus.wr_addr != ZERO_REG
             && bus.wr_addr == bus.rs1_addr;
  assign fwd2 = bus.wr_en
             && bus.wr_addr != ZERO_REG
             && bus.wr_addr == bus.rs2_addr;

  assign bus.rs1_data = fwd1 ? bus.wr_data : rd1;
  assign bus.rs2_data = fwd2 ? bus.wr_data : rd2;
`else
  assign bus.rs1_data = rd1;
  assign bus.rs2_data = rd2;
`endif

  reg_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (bus.rs1_addr),
    .rs2_addr    (bus.rs2_addr),
    .rs1_used    (bus.rs1_used),
    .rs2_used    (bus.rs2_used),
    .wr_en       (bus.wr_en),
    .wr_addr     (bus.wr_addr),
    .wr_clr_busy (bus.wr_clr_busy),
    .issue_en    (bus.issue_en),
    .issue_rd    (bus.issue_rd),
    .issue_long  (bus.issue_long),
    .stall       (bus.stall),
    .busy_vec    (bus.busy_vec)
  );

endmodule

// File: tb/tb_reg_bank_sb.sv
// Self-checking bench for reg_bank_sb against a behavioural model.
// Works in both builds (REG_BYPASS_EN defined or not).
module tb_reg_bank_sb;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  reg_bank_sb_if bus ();

  reg_bank_sb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Model: architectural register values and outstanding producers.
  logic [31:0] mreg [32];
  bit          mbusy [32];

  function automatic bit clearing(input int a);
    return bus.wr_en && bus.wr_clr_busy && int'(bus.wr_addr) == a;
  endfunction

  function automatic bit seen_busy(input int a);
    return mbusy[a] && !(BYP && clearing(a));
  endfunction

  function automatic logic [31:0] exp_read(input int a);
    if (a == 0) return 32'h0;
    if (BYP && bus.wr_en && int'(bus.wr_addr) == a)
      return bus.wr_data;
    return mreg[a];
  endfunction

  function automatic logic exp_stall();
    return (bus.rs1_used && seen_busy(int'(bus.rs1_addr)))
        || (bus.rs2_used && seen_busy(int'(bus.rs2_addr)))
        || (bus.issue_en && seen_busy(int'(bus.issue_rd)));
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mbusy[i];
    return v;
  endfunction

  // Advance one clock: inputs stay stable from negedge to negedge.
  task automatic tick();
    bit fire;
    fire = bus.issue_en && !exp_stall();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mreg[i] = 0;
        mbusy[i] = 0;
      end
    end else begin
      if (bus.wr_en && bus.wr_addr != 0)
        mreg[bus.wr_addr] = bus.wr_data;
      if (bus.wr_en && bus.wr_clr_busy)
        mbusy[bus.wr_addr] = 0;
      if (fire && bus.issue_long && bus.issue_rd != 0)
        mbusy[bus.issue_rd] = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0;
    bus.rs1_addr = 0;
    bus.rs2_addr = 0;
    bus.rs1_used = 0;
    bus.rs2_used = 0;
    bus.wr_en = 0;
    bus.wr_addr = 0;
    bus.wr_data = 0;
    bus.wr_clr_busy = 0;
    bus.issue_en = 0;
    bus.issue_rd = 0;
    bus.issue_long = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr = 5'(i);
      bus.rs2_addr = 5'(31 - i);
      #1;
      checks++;
      if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_read idx=%0d got %h/%h want 0",
                 i, bus.rs1_data, bus.rs2_data);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.stall !== 1'b0 || bus.busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL reset_sb got stall=%b busy=%h want 0/0",
               bus.stall, bus.busy_vec);
    end
  endtask

  task automatic test_write_read();
    idle();
    bus.wr_en = 1;
    bus.wr_addr = 5;
    bus.wr_data = 32'hDEADBEEF;
    tick();
    idle();
    bus.rs1_addr = 5;
    bus.rs2_addr = 5;
    #1;
    checks++;
    if (bus.rs1_data !== 32'hDEADBEEF || bus.rs2_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_x5 got %h/%h want deadbeef",
               bus.rs1_data, bus.rs2_data);
    end
    @(negedge clk);
    bus.wr_en = 1;
    bus.wr_addr = 0;
    bus.wr_data = 32'h12345678;
    bus.rs1_addr = 0;
    #1;
    checks++;
    if (bus.rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_same got %h want 0", bus.rs1_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_after got %h want 0", bus.rs1_data);
    end
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    logic [31:0] want;
    idle();
    bus.wr_en = 1;
    bus.wr_addr = 7;
    bus.wr_data = 32'h11111111;
    tick();
    bus.wr_data = 32'hA5A5A5A5;
    bus.rs1_addr = 7;
    bus.rs2_addr = 7;
    want = BYP ? 32'hA5A5A5A5 : 32'h11111111;
    #1;
    checks++;
    if (bus.rs1_data !== want || bus.rs2_data !== want) begin
      errors++;
      $display("FAIL fwd_x7 got %h/%h want %h",
               bus.rs1_data, bus.rs2_data, want);
    end
    tick();
    bus.wr_en = 0;
    #1;
    checks++;
    if (bus.rs1_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL next_x7 got %h want a5a5a5a5", bus.rs1_data);
    end
    @(negedge clk);
  endtask

  task automatic test_raw_stall();
    idle();
    bus.issue_en = 1;
    bus.issue_rd = 3;
    bus.issue_long = 1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL issue_x3 got stall=%b want 0", bus.stall);
    end
    tick();
    idle();
    bus.rs1_addr = 3;
    bus.rs1_used = 1;
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.busy_vec[3] !== 1'b1) begin
      errors++;
      $display("FAIL raw_x3 got stall=%b busy3=%b want 1/1",
               bus.stall, bus.busy_vec[3]);
    end
    @(negedge clk);
    bus.wr_en = 1;
    bus.wr_addr = 3;
    bus.wr_data = 32'h33;
    bus.wr_clr_busy = 1;
    #1;
    checks++;
    if (bus.stall !== !BYP) begin
      errors++;
      $display("FAIL clr_same got stall=%b want %b", bus.stall, !BYP);
    end
    tick();
    bus.wr_en = 0;
    bus.wr_clr_busy = 0;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.busy_vec[3] !== 1'b0) begin
      errors++;
      $display("FAIL clr_next got stall=%b busy3=%b want 0/0",
               bus.stall, bus.busy_vec[3]);
    end
    @(negedge clk);
  endtask

  task automatic test_set_wins();
    idle();
    bus.wr_en = 1;
    bus.wr_addr = 9;
    bus.wr_data = 32'h99;
    bus.wr_clr_busy = 1;
    bus.issue_en = 1;
    bus.issue_rd = 9;
    bus.issue_long = 1;
    tick();
    idle();
    #1;
    checks++;
    if (bus.busy_vec[9] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins got busy9=%b want 1", bus.busy_vec[9]);
    end
    bus.issue_en = 1;
    bus.issue_rd = 9;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL waw_x9 got stall=%b want 1", bus.stall);
    end
    tick();
    idle();
    bus.wr_en = 1;
    bus.wr_addr = 9;
    bus.wr_clr_busy = 1;
    tick();
    idle();
  endtask

  task automatic test_reset_midop();
    idle();
    bus.issue_en = 1;
    bus.issue_long = 1;
    bus.issue_rd = 4;
    tick();
    bus.issue_rd = 6;
    tick();
    idle();
    #1;
    checks++;
    if (bus.busy_vec !== 32'h50) begin
      errors++;
      $display("FAIL busy_4_6 got %h want 00000050", bus.busy_vec);
    end
    rst = 1;
    bus.wr_en = 1;
    bus.wr_addr = 4;
    bus.wr_data = 32'hCAFEF00D;
    bus.issue_en = 1;
    bus.issue_rd = 8;
    bus.issue_long = 1;
    tick();
    idle();
    bus.rs1_addr = 4;
    bus.rs1_used = 1;
    bus.rs2_addr = 6;
    bus.rs2_used = 1;
    #1;
    checks++;
    if (bus.busy_vec !== 32'h0 || bus.rs1_data !== 32'h0
        || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_midop got busy=%h x4=%h stall=%b want 0/0/0",
               bus.busy_vec, bus.rs1_data, bus.stall);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 59) == 0);
      bus.rs1_addr = 5'($urandom_range(0, 7));
      bus.rs2_addr = 5'($urandom_range(0, 7));
      bus.rs1_used = 1'($urandom);
      bus.rs2_used = 1'($urandom);
      bus.wr_en = 1'($urandom);
      bus.wr_addr = 5'($urandom_range(0, 7));
      bus.wr_data = $urandom;
      bus.wr_clr_busy = 1'($urandom);
      bus.issue_en = 1'($urandom);
      bus.issue_rd = 5'($urandom_range(0, 7));
      bus.issue_long = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (bus.rs1_data !== exp_read(int'(bus.rs1_addr))
          || bus.rs2_data !== exp_read(int'(bus.rs2_addr))
          || bus.stall !== exp_stall()
          || bus.busy_vec !== exp_busy()) begin
        errors++;
        $display("FAIL rand n=%0d got %h %h %b %h want %h %h %b %h",
                 n, bus.rs1_data, bus.rs2_data, bus.stall,
                 bus.busy_vec, exp_read(int'(bus.rs1_addr)),
                 exp_read(int'(bus.rs2_addr)), exp_stall(),
                 exp_busy());
      end
      tick();
    end
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_same_cycle();
    test_raw_stall();
    test_set_wins();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
